// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit with a valid/ready handshake on both sides.
// Divides use restoring radix-2; multiplies are single-cycle or shift-add, depending on FAST_MUL.
module muldiv_unit #(
   parameter int XLEN     = 32,
   parameter bit FAST_MUL = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] res,
   output logic            div_by_zero
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [XLEN-1:0]   mag_a_q, mag_a_d;
   logic [XLEN-1:0]   mag_b_q, mag_b_d;
   logic [XLEN-1:0]   hi_q, hi_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   logic              neg_res_q, neg_res_d;
   logic              neg_a_q, neg_a_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   res_q, res_d;
   logic              dbz_q, dbz_d;

   logic              a_signed, b_signed, in_neg_a, in_neg_b;
   logic [XLEN-1:0]   in_mag_a, in_mag_b;
   logic [2*XLEN-1:0] fast_prod;
   logic [XLEN:0]     rem_sh, rem_diff, mul_sum;
   logic [XLEN-1:0]   step_hi, step_lo;

   // Operates on unsigned magnitudes; signs are restored here on the way into DONE.
   function automatic logic [XLEN-1:0] finalize(input logic [2:0] f_op,
                                                input logic [XLEN-1:0] f_hi,
                                                input logic [XLEN-1:0] f_lo,
                                                input logic f_neg_res,
                                                input logic f_neg_a);
      logic [2*XLEN-1:0] p;
      logic [XLEN-1:0]   r;
      p = {f_hi, f_lo};
      if (f_neg_res) p = -p;
      if (!f_op[2])
         r = (f_op[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
      else if (!f_op[1])
         r = f_neg_res ? -f_lo : f_lo;
      else
         r = f_neg_a ? -f_hi : f_hi;
      return r;
   endfunction

   assign a_signed  = !((op == 3'b011) || (op == 3'b101) || (op == 3'b111));
   assign b_signed  = a_signed && (op != 3'b010);
   assign in_neg_a  = a_signed & a[XLEN-1];
   assign in_neg_b  = b_signed & b[XLEN-1];
   assign in_mag_a  = in_neg_a ? (~a + 1'b1) : a;
   assign in_mag_b  = in_neg_b ? (~b + 1'b1) : b;
   assign fast_prod = {{XLEN{1'b0}}, in_mag_a} * {{XLEN{1'b0}}, in_mag_b};

   // hi holds the partial remainder / upper product, lo the dividend-quotient / multiplier.
   assign rem_sh   = {hi_q, lo_q[XLEN-1]};
   assign rem_diff = rem_sh - {1'b0, mag_b_q};
   assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_a_q} : {(XLEN+1){1'b0}});

   always_comb begin
      step_hi = hi_q;
      step_lo = lo_q;
      if (op_q[2]) begin
         if (!rem_diff[XLEN]) begin
            step_hi = rem_diff[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], 1'b1};
         end else begin
            step_hi = rem_sh[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], 1'b0};
         end
      end else begin
         step_hi = mul_sum[XLEN:1];
         step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      mag_a_d   = mag_a_q;
      mag_b_d   = mag_b_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      neg_res_d = neg_res_q;
      neg_a_d   = neg_a_q;
      cnt_d     = cnt_q;
      res_d     = res_q;
      dbz_d     = dbz_q;
      case (state_q)
         IDLE: begin
            if (in_valid && !rst) begin
               op_d      = op;
               mag_a_d   = in_mag_a;
               mag_b_d   = in_mag_b;
               neg_res_d = in_neg_a ^ in_neg_b;
               neg_a_d   = in_neg_a;
               cnt_d     = '0;
               dbz_d     = 1'b0;
               hi_d      = '0;
               lo_d      = op[2] ? in_mag_a : in_mag_b;
               if (op[2] && (b == '0)) begin
                  res_d   = op[1] ? a : '1;
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else if (op[2] && !op[0] && (a == MIN_NEG) && (b == '1)) begin
                  res_d   = op[1] ? '0 : a;
                  state_d = DONE;
               end else if (FAST_MUL && !op[2]) begin
                  res_d   = finalize(op, fast_prod[2*XLEN-1:XLEN], fast_prod[XLEN-1:0],
                                     in_neg_a ^ in_neg_b, in_neg_a);
                  state_d = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN-1)) begin
               res_d   = finalize(op_q, step_hi, step_lo, neg_res_q, neg_a_q);
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         op_q      <= '0;
         mag_a_q   <= '0;
         mag_b_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         neg_res_q <= 1'b0;
         neg_a_q   <= 1'b0;
         cnt_q     <= '0;
         res_q     <= '0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         mag_a_q   <= mag_a_d;
         mag_b_q   <= mag_b_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         neg_res_q <= neg_res_d;
         neg_a_q   <= neg_a_d;
         cnt_q     <= cnt_d;
         res_q     <= res_d;
         dbz_q     <= dbz_d;
      end
   end

   assign in_ready    = (state_q == IDLE) & ~rst;
   assign out_valid   = (state_q == DONE);
   assign res         = res_q;
   assign div_by_zero = dbz_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multiply/divide unit implementing all eight RV32M operations. It generalises the combinational ALU M-extension path into a handshaked, multi-cycle block.
- Sits beside the ALU in the execute stage. The pipeline stalls on in_ready/out_valid instead of computing divide combinationally.
- Returns RISC-V-defined results for divide-by-zero and signed overflow. It never leaves a result undefined.

Parameters:
- XLEN, 32: operand/result width in bits (>= 8, even).
- FAST_MUL, 1: 1 = multiply result registered one cycle after accept; 0 = iterative shift-add multiply, XLEN cycles.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  XLEN  rs1 operand.
- b  in  XLEN  rs2 operand.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- res  out  XLEN  result.
- div_by_zero  out  1  qualified by out_valid; set for a division-class op with b == 0.

Behaviour:
- Reset (async, immediate): state IDLE, out_valid 0, res 0, div_by_zero 0, counter 0. in_ready is 0 while rst is high.
- FSM states: IDLE, CALC, DONE. in_ready = (state == IDLE) & ~rst.
- Accept occurs when in_valid & in_ready at edge T. The unit latches op, magnitudes |a| and |b| (signed per op), the result sign, and the raw a.
- MULHSU: a is signed, b is unsigned. MULHU, DIVU, REMU: both operands unsigned.
- Fast path, IDLE -> DONE at edge T; out_valid high in cycle T+1. Taken for:
  - b == 0 on DIV or DIVU: res = all ones, div_by_zero = 1.
  - b == 0 on REM or REMU: res = a, div_by_zero = 1.
  - DIV with a = 2^(XLEN-1) and b = -1: res = a, no flag.
  - REM with a = 2^(XLEN-1) and b = -1: res = 0, no flag.
  - Any multiply when FAST_MUL = 1: full 2*XLEN product computed and registered.
- Iterative path, IDLE -> CALC at edge T.
  - Divide: restoring radix-2, one quotient bit per cycle, XLEN cycles.
  - Multiply (FAST_MUL = 0): shift-add over unsigned magnitudes, XLEN cycles.
  - The counter starts at 0. CALC -> DONE on the edge where counter == XLEN-1, so out_valid is high from cycle T+XLEN+1.
  - Final sign fix-up is applied when entering DONE.
- Result selection:
  - MUL: product[XLEN-1:0].
  - MULH, MULHSU, MULHU: product[2*XLEN-1:XLEN], with the signed product as two's complement.
  - DIV: quotient takes the sign of a XOR b.
  - REM: remainder takes the sign of the dividend a.
- DONE: res, div_by_zero and out_valid are held stable until out_valid & out_ready. On that handshake, go to IDLE and clear out_valid. in_ready rises the following cycle; there is no same-cycle accept.
- in_valid while busy is ignored. The upstream stage must hold the request.
- Inputs a, b and op may change after accept without affecting the in-flight operation.
- div_by_zero is 0 for all multiply ops.
- Reset mid-CALC or mid-DONE aborts the operation; no out_valid is produced afterwards.

Test Plan:
- DIV a=-7, b=2 -> out_valid after 33 cycles; res=0xFFFFFFFD (-3). REM of the same operands -> res=0xFFFFFFFF (-1).
- DIVU a=0x12345678, b=0 -> out_valid at T+1; res=0xFFFFFFFF, div_by_zero=1. REMU of the same operands -> res=0x12345678, div_by_zero=1.
- DIV a=0x80000000, b=0xFFFFFFFF -> res=0x80000000, div_by_zero=0, 1-cycle latency. REM of the same operands -> res=0.
- MULH a=0x80000000, b=0x80000000 -> res=0x40000000. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> res=0xFFFFFFFF. MULHU of the same operands -> res=0xFFFFFFFE. MUL of the same operands -> res=0x00000001. Run at FAST_MUL=1 (T+1) and at FAST_MUL=0 (T+33).
- Backpressure: hold out_ready=0 for 5 cycles after DIVU 100/7 -> res=14 held stable, in_ready=0 throughout, extra in_valid ignored. Assert out_ready -> in_ready=1 next cycle.
- Assert rst at cycle 10 of a DIV -> out_valid=0 and in_ready=0 immediately. After release, a new DIVU 9/3 returns res=3.
